// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO between the UART receiver holding register and the bus read mux.
// Define UART_RX_FIFO_RTS_EN to drive rts from the fill level; otherwise rts is tied low.
module uart_rx_fifo #(
  parameter int DEPTH      = 4,
  parameter int RTS_MARGIN = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [7:0]                 in_data,
  output logic                       in_ready,
  input  logic                       rd,
  input  logic                       flush,
  output logic [7:0]                 out_data,
  output logic                       out_valid,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       rts
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0 ||
      RTS_MARGIN < 0 || RTS_MARGIN >= DEPTH) begin : g_param_check
    $error("uart_rx_fifo: DEPTH must be a power of two in 2..16 and RTS_MARGIN in 0..DEPTH-1");
  end

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic          push;
  logic          pop;

  assign in_ready  = (count != FULL);
  assign push      = in_valid & in_ready;
  assign pop       = rd & (count != '0);
  assign out_valid = (count != '0);
  assign out_data  = out_valid ? mem[rp] : 8'hFF;
  assign level     = count;

  // NOTE: give every always_comb output a default first so no path leaves it unassigned (no latch).
  always_comb begin
    count_next = count;
    if (flush) begin
      count_next = '0;
    end else begin
      unique case ({push, pop})
        2'b10:   count_next = count + 1'b1;
        2'b01:   count_next = count - 1'b1;
        default: count_next = count;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else if (flush) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      count <= count_next;
    end
  end

  // NOTE: the byte array has no reset; count gates out_data, so stale entries are never visible.
  always_ff @(posedge clk) begin
    if (push && !flush && !rst) begin
      mem[wp] <= in_data;
    end
  end

`ifdef UART_RX_FIFO_RTS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      rts <= 1'b0;
    end else begin
      rts <= ((FULL - count_next) <= CW'(RTS_MARGIN));
    end
  end
`else
  assign rts = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo (DEPTH=4, RTS_MARGIN=1); rts checks follow UART_RX_FIFO_RTS_EN.
module tb_uart_rx_fifo;

`ifdef UART_RX_FIFO_RTS_EN
  localparam bit RTS_ON = 1'b1;
`else
  localparam bit RTS_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       rd;
  logic       flush;
  logic [7:0] out_data;
  logic       out_valid;
  logic [2:0] level;
  logic       rts;

  int tests_run    = 0;
  int tests_failed = 0;

  uart_rx_fifo #(.DEPTH(4), .RTS_MARGIN(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .rd(rd), .flush(flush), .out_data(out_data), .out_valid(out_valid),
    .level(level), .rts(rts)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic pop_byte();
    rd = 1'b1;
    tick();
    rd = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; rd = 1'b0; flush = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tests_run++; if (level !== 3'd0) begin tests_failed++; $display("FAIL reset_level got %0d want 0", level); end
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    tests_run++; if (out_data !== 8'hFF) begin tests_failed++; $display("FAIL reset_out_data got %h want ff", out_data); end
    tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    tests_run++; if (rts !== 1'b0) begin tests_failed++; $display("FAIL reset_rts got %b want 0", rts); end
  endtask

  task automatic test_single();
    push_byte(8'h41);
    tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL single_out_valid got %b want 1", out_valid); end
    tests_run++; if (out_data !== 8'h41) begin tests_failed++; $display("FAIL single_out_data got %h want 41", out_data); end
    tests_run++; if (level !== 3'd1) begin tests_failed++; $display("FAIL single_level got %0d want 1", level); end
    pop_byte();
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL single_pop_valid got %b want 0", out_valid); end
    tests_run++; if (out_data !== 8'hFF) begin tests_failed++; $display("FAIL single_pop_data got %h want ff", out_data); end
    tests_run++; if (level !== 3'd0) begin tests_failed++; $display("FAIL single_pop_level got %0d want 0", level); end
  endtask

  task automatic test_full();
    logic [7:0] exp_b [4];
    exp_b[0] = 8'h11; exp_b[1] = 8'h12; exp_b[2] = 8'h13; exp_b[3] = 8'h14;
    push_byte(8'h10); push_byte(8'h11); push_byte(8'h12); push_byte(8'h13);
    tests_run++; if (level !== 3'd4) begin tests_failed++; $display("FAIL full_level got %0d want 4", level); end
    tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL full_in_ready got %b want 0", in_ready); end
    in_valid = 1'b1; in_data = 8'h14;
    tick();
    tests_run++; if (level !== 3'd4) begin tests_failed++; $display("FAIL full_blocked_level got %0d want 4", level); end
    tests_run++; if (out_data !== 8'h10) begin tests_failed++; $display("FAIL full_blocked_head got %h want 10", out_data); end
    rd = 1'b1;
    tick();
    rd = 1'b0;
    tests_run++; if (out_data !== 8'h11) begin tests_failed++; $display("FAIL full_pop_head got %h want 11", out_data); end
    tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL full_pop_in_ready got %b want 1", in_ready); end
    tests_run++; if (level !== 3'd3) begin tests_failed++; $display("FAIL full_pop_level got %0d want 3", level); end
    tick();
    in_valid = 1'b0;
    tests_run++; if (level !== 3'd4) begin tests_failed++; $display("FAIL full_refill_level got %0d want 4", level); end
    for (int i = 0; i < 4; i++) begin
      tests_run++; if (out_data !== exp_b[i]) begin tests_failed++; $display("FAIL full_drain_%0d got %h want %h", i, out_data, exp_b[i]); end
      pop_byte();
    end
    tests_run++; if (level !== 3'd0) begin tests_failed++; $display("FAIL full_drain_level got %0d want 0", level); end
  endtask

  task automatic test_simultaneous();
    push_byte(8'h20); push_byte(8'h21);
    in_valid = 1'b1; in_data = 8'hAA; rd = 1'b1;
    tick();
    in_valid = 1'b0; rd = 1'b0;
    tests_run++; if (level !== 3'd2) begin tests_failed++; $display("FAIL simul_level got %0d want 2", level); end
    tests_run++; if (out_data !== 8'h21) begin tests_failed++; $display("FAIL simul_head got %h want 21", out_data); end
    pop_byte();
    tests_run++; if (out_data !== 8'hAA) begin tests_failed++; $display("FAIL simul_second got %h want aa", out_data); end
    tests_run++; if (level !== 3'd1) begin tests_failed++; $display("FAIL simul_second_level got %0d want 1", level); end
    pop_byte();
  endtask

  task automatic test_wrap();
    logic [7:0] b;
    push_byte(8'h30);
    for (int i = 0; i < 10; i++) begin
      b = 8'h30 + 8'(i);
      tests_run++; if (out_data !== b) begin tests_failed++; $display("FAIL wrap_%0d got %h want %h", i, out_data, b); end
      in_valid = (i < 9); in_data = b + 8'h01; rd = 1'b1;
      tick();
      in_valid = 1'b0; rd = 1'b0;
    end
    tests_run++; if (level !== 3'd0) begin tests_failed++; $display("FAIL wrap_level got %0d want 0", level); end
  endtask

  task automatic test_empty_rd();
    rd = 1'b1;
    tick(); tick(); tick();
    rd = 1'b0;
    tests_run++; if (level !== 3'd0) begin tests_failed++; $display("FAIL empty_rd_level got %0d want 0", level); end
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL empty_rd_valid got %b want 0", out_valid); end
    push_byte(8'h5A);
    tests_run++; if (out_data !== 8'h5A) begin tests_failed++; $display("FAIL empty_rd_push got %h want 5a", out_data); end
    tests_run++; if (level !== 3'd1) begin tests_failed++; $display("FAIL empty_rd_push_level got %0d want 1", level); end
    pop_byte();
  endtask

  task automatic test_flush();
    push_byte(8'h01); push_byte(8'h02); push_byte(8'h03);
    tests_run++; if (level !== 3'd3) begin tests_failed++; $display("FAIL flush_pre_level got %0d want 3", level); end
    flush = 1'b1; in_valid = 1'b1; in_data = 8'h77;
    tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL flush_in_ready got %b want 1", in_ready); end
    tick();
    flush = 1'b0; in_valid = 1'b0;
    tests_run++; if (level !== 3'd0) begin tests_failed++; $display("FAIL flush_level got %0d want 0", level); end
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL flush_valid got %b want 0", out_valid); end
    tests_run++; if (out_data !== 8'hFF) begin tests_failed++; $display("FAIL flush_data got %h want ff", out_data); end
    push_byte(8'h88);
    tests_run++; if (out_data !== 8'h88) begin tests_failed++; $display("FAIL flush_after_push got %h want 88", out_data); end
    pop_byte();
  endtask

  task automatic test_rts();
    push_byte(8'hC0); push_byte(8'hC1);
    tests_run++; if (rts !== 1'b0) begin tests_failed++; $display("FAIL rts_level2 got %b want 0", rts); end
    push_byte(8'hC2);
    tests_run++; if (rts !== RTS_ON) begin tests_failed++; $display("FAIL rts_level3 got %b want %b", rts, RTS_ON); end
    push_byte(8'hC3);
    tests_run++; if (rts !== RTS_ON) begin tests_failed++; $display("FAIL rts_level4 got %b want %b", rts, RTS_ON); end
    pop_byte(); pop_byte();
    tests_run++; if (level !== 3'd2) begin tests_failed++; $display("FAIL rts_pop_level got %0d want 2", level); end
    tests_run++; if (rts !== 1'b0) begin tests_failed++; $display("FAIL rts_pop_level2 got %b want 0", rts); end
    pop_byte(); pop_byte();
  endtask

  task automatic test_reset_mid();
    push_byte(8'hE0); push_byte(8'hE1); push_byte(8'hE2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests_run++; if (level !== 3'd0) begin tests_failed++; $display("FAIL midrst_level got %0d want 0", level); end
    tests_run++; if (out_data !== 8'hFF) begin tests_failed++; $display("FAIL midrst_data got %h want ff", out_data); end
    tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL midrst_in_ready got %b want 1", in_ready); end
    tests_run++; if (rts !== 1'b0) begin tests_failed++; $display("FAIL midrst_rts got %b want 0", rts); end
    push_byte(8'h99);
    tests_run++; if (out_data !== 8'h99) begin tests_failed++; $display("FAIL midrst_push got %h want 99", out_data); end
    pop_byte();
  endtask

  initial begin
    test_reset();
    test_single();
    test_full();
    test_simultaneous();
    test_wrap();
    test_empty_rd();
    test_flush();
    test_rts();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
